// File: rtl/snn_pkg.sv
// Shared types and address-map helpers for the LIF neuron layer.
//   lif_state_t : layer sequencer states
//   thr_addr()  : word address of the threshold register
//   pot_base()  : word address of potential[0]; potential[n] sits at pot_base() + n
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ACCUM  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } lif_state_t;

  function automatic int unsigned thr_addr(input int unsigned num_neurons,
                                           input int unsigned num_inputs);
    return num_neurons * num_inputs;
  endfunction

  function automatic int unsigned pot_base(input int unsigned num_neurons,
                                           input int unsigned num_inputs);
    return thr_addr(num_neurons, num_inputs) + 1;
  endfunction

endpackage

// File: rtl/snn_weight_ram.sv
// Synchronous dual-port weight memory, no reset (contents are host-configured).
//   clk        : clock
//   host_wen   : host write enable (already qualified by the caller)
//   host_addr  : host word address, shared by the host write and host read
//   host_wdata : host write data
//   host_rdata : host read data, one cycle after host_addr (read-before-write)
//   rd_addr    : sequencer read address
//   rd_data    : sequencer read data, one cycle after rd_addr
module snn_weight_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             host_wen,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (host_wen) begin
      mem[host_addr] <= host_wdata;
    end
    host_rdata <= mem[host_addr];
    rd_data    <= mem[rd_addr];
  end

endmodule

// File: rtl/lif_neuron_layer.sv
// Layer of leaky integrate-and-fire neurons fed by a spike vector once per step.
// Neurons and their inputs are walked serially, one weight read per cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   spikes_in     : input spike vector, captured when step_valid & step_ready
//   step_valid    : spikes_in valid
//   step_ready    : layer idle
//   spikes_out    : output spike vector, held until the next out_valid
//   out_valid     : one-cycle pulse when spikes_out updates
//   busy          : a step is in progress
//   mem_addr      : host word address
//   mem_wen       : host write enable (ignored while busy)
//   mem_data_in   : host write data
//   mem_data_out  : host read data, one cycle after mem_addr
//
// state  | meaning
// IDLE   | waiting for a step; host may write weights/threshold
// FETCH  | issue read of weight (n,0), clear sum
// ACCUM  | add weight (n,i) when spike i is set, issue read of (n,i+1)
// UPDATE | leak, integrate, clamp, fire/refractory for neuron n
// DONE   | publish spike vector, pulse out_valid
module lif_neuron_layer
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS     = 32,
  parameter int NUM_NEURONS    = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int POT_WIDTH      = 16,
  parameter int THRESH_DEFAULT = 1000,
  parameter int LEAK_SHIFT     = 4,
  parameter int REFRACT_STEPS  = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  spikes_in,
  input  logic                   step_valid,
  output logic                   step_ready,
  output logic [NUM_NEURONS-1:0] spikes_out,
  output logic                   out_valid,
  output logic                   busy,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_wen,
  input  logic [DATA_WIDTH-1:0]  mem_data_in,
  output logic [DATA_WIDTH-1:0]  mem_data_out
);

  localparam int DEPTH  = NUM_NEURONS * NUM_INPUTS;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int IW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int SUM_W  = WEIGHT_WIDTH + $clog2(NUM_INPUTS) + 1;
  // Wide enough that v - leak + sum can never wrap before the clamp, even
  // when the summed weights are wider than the potential.
  localparam int CALC_W = (POT_WIDTH + 2 > SUM_W + 2) ? POT_WIDTH + 2 : SUM_W + 2;
  localparam int RW     = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] W_END   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] THR_A   = ADDR_WIDTH'(thr_addr(NUM_NEURONS, NUM_INPUTS));
  localparam logic [ADDR_WIDTH-1:0] POT_A   = ADDR_WIDTH'(pot_base(NUM_NEURONS, NUM_INPUTS));
  localparam logic [ADDR_WIDTH-1:0] POT_END =
    ADDR_WIDTH'(pot_base(NUM_NEURONS, NUM_INPUTS) + NUM_NEURONS);
  localparam logic signed [CALC_W-1:0] POT_MAX =
    {{(CALC_W-POT_WIDTH){1'b0}}, {POT_WIDTH{1'b1}}};

  lif_state_t state_q, state_d;

  logic [NW-1:0]           n_q;
  logic [IW-1:0]           i_q;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] w_ext;
  logic [NUM_INPUTS-1:0]   spk_cap_q;
  logic [NUM_NEURONS-1:0]  spk_acc_q;
  logic [NUM_NEURONS-1:0]  spikes_out_q;
  logic                    out_valid_q;
  logic [POT_WIDTH-1:0]    pot_q  [NUM_NEURONS];
  logic [RW-1:0]           refr_q [NUM_NEURONS];
  logic [POT_WIDTH-1:0]    thr_q;

  logic [WEIGHT_WIDTH-1:0] host_rdata;
  logic [WEIGHT_WIDTH-1:0] fsm_rdata;
  logic [RAM_AW-1:0]       fsm_raddr;
  logic [RAM_AW-1:0]       fsm_base;
  logic                    host_wen;

  logic                    hit_w, hit_thr, hit_pot;
  logic [NW-1:0]           pot_idx;
  logic                    sel_w_q;
  logic [DATA_WIDTH-1:0]   rd_other_q;

  logic signed [CALC_W-1:0] v_new;
  logic [POT_WIDTH-1:0]     v_sat;
  logic                     fire;
  logic                     unused_hi;

  assign busy       = (state_q != IDLE);
  assign step_ready = (state_q == IDLE);
  assign spikes_out = spikes_out_q;
  assign out_valid  = out_valid_q;
  assign unused_hi  = ^mem_data_in[DATA_WIDTH-1:POT_WIDTH];

  // Host address decode
  assign hit_w    = (mem_addr < W_END);
  assign hit_thr  = (mem_addr == THR_A);
  assign hit_pot  = (mem_addr >= POT_A) && (mem_addr < POT_END);
  assign pot_idx  = NW'(mem_addr - POT_A);
  assign host_wen = mem_wen && !busy && hit_w;

  snn_weight_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WEIGHT_WIDTH),
    .AW    (RAM_AW)
  ) u_weight_ram (
    .clk        (clk),
    .host_wen   (host_wen),
    .host_addr  (mem_addr[RAM_AW-1:0]),
    .host_wdata (mem_data_in[WEIGHT_WIDTH-1:0]),
    .host_rdata (host_rdata),
    .rd_addr    (fsm_raddr),
    .rd_data    (fsm_rdata)
  );

  // Weight reads come straight from the RAM output register; everything else
  // from rd_other_q. Both are flops, so the read latency is one cycle either way.
  assign mem_data_out = sel_w_q
    ? {{(DATA_WIDTH-WEIGHT_WIDTH){host_rdata[WEIGHT_WIDTH-1]}}, host_rdata}
    : rd_other_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q      <= POT_WIDTH'(THRESH_DEFAULT);
      sel_w_q    <= 1'b0;
      rd_other_q <= '0;
    end else begin
      if (mem_wen && !busy && hit_thr) begin
        thr_q <= mem_data_in[POT_WIDTH-1:0];
      end
      sel_w_q <= hit_w;
      if (hit_thr) begin
        rd_other_q <= DATA_WIDTH'(thr_q);
      end else if (hit_pot) begin
        rd_other_q <= DATA_WIDTH'(pot_q[pot_idx]);
      end else begin
        rd_other_q <= '0;
      end
    end
  end

  // Read (n,0) in FETCH, then (n,i+1) during ACCUM so data lines up with i_q.
  always_comb begin
    fsm_base  = RAM_AW'(n_q) * RAM_AW'(NUM_INPUTS);
    fsm_raddr = fsm_base;
    if (state_q == ACCUM && i_q != IW'(NUM_INPUTS - 1)) begin
      fsm_raddr = fsm_base + RAM_AW'(i_q) + RAM_AW'(1);
    end
  end

  assign w_ext = {{(SUM_W-WEIGHT_WIDTH){fsm_rdata[WEIGHT_WIDTH-1]}}, fsm_rdata};

  always_comb begin
    v_new = $signed({{(CALC_W-POT_WIDTH){1'b0}}, pot_q[n_q]})
          - $signed({{(CALC_W-POT_WIDTH){1'b0}}, pot_q[n_q] >> LEAK_SHIFT})
          + $signed({{(CALC_W-SUM_W){sum_q[SUM_W-1]}}, sum_q});
    if (v_new[CALC_W-1]) begin
      v_sat = '0;
    end else if (v_new > POT_MAX) begin
      v_sat = {POT_WIDTH{1'b1}};
    end else begin
      v_sat = v_new[POT_WIDTH-1:0];
    end
    fire = (v_sat >= thr_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_valid) state_d = FETCH;
      FETCH:   state_d = ACCUM;
      ACCUM:   if (i_q == IW'(NUM_INPUTS - 1)) state_d = UPDATE;
      UPDATE:  state_d = (n_q == NW'(NUM_NEURONS - 1)) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      i_q          <= '0;
      sum_q        <= '0;
      spk_cap_q    <= '0;
      spk_acc_q    <= '0;
      spikes_out_q <= '0;
      out_valid_q  <= 1'b0;
      pot_q        <= '{default: '0};
      refr_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (step_valid) begin
            spk_cap_q <= spikes_in;
            spk_acc_q <= '0;
            n_q       <= '0;
          end
        end
        FETCH: begin
          sum_q <= '0;
          i_q   <= '0;
        end
        ACCUM: begin
          if (spk_cap_q[i_q]) begin
            sum_q <= sum_q + w_ext;
          end
          i_q <= i_q + IW'(1);
        end
        UPDATE: begin
          if (refr_q[n_q] != '0) begin
            refr_q[n_q] <= refr_q[n_q] - RW'(1);
            pot_q[n_q]  <= '0;
          end else if (fire) begin
            spk_acc_q[n_q] <= 1'b1;
            pot_q[n_q]     <= '0;
            refr_q[n_q]    <= RW'(REFRACT_STEPS);
          end else begin
            pot_q[n_q] <= v_sat;
          end
          n_q <= n_q + NW'(1);
        end
        DONE: begin
          spikes_out_q <= spk_acc_q;
          out_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
